// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the RV32I fetch front end.
//   XLEN             - architectural register/address width
//   DEFAULT_RESET_PC - default first fetch address after reset
//   INSTR_BYTES      - byte stride between sequential RV32I instructions
//   fetch_pkt_t      - {pc, instr} pair handed from fetch to decode
//   next_pc()        - sequential successor of a fetch address (wraps mod 2^32)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES      = 32'h0000_0004;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // Sequential fetch address; overflow past 0xFFFF_FFFC wraps silently to 0.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur);
    return cur + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: show-ahead synchronous FIFO with synchronous clear.
//   clk, reset     - clock and synchronous active-high reset
//   clear          - synchronous flush; overrides push/pop in its cycle
//   push/push_data - write request; ignored when full unless a pop frees a slot
//   pop            - remove head; ignored when empty
//   head_data      - current head entry (all zeros while empty)
//   count          - number of stored entries, 0..DEPTH
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_ONE;
    end
  endfunction

  // Qualify push/pop against occupancy; a full FIFO may accept a push only alongside a pop.
  always_comb begin
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= inc_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= inc_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear && !reset) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Show-ahead head; forced to zero while empty so downstream never sees stale data.
  always_comb begin
    if (count_r != {CNT_W{1'b0}}) begin
      head_data = mem_r[rd_ptr_r];
    end else begin
      head_data = {WIDTH{1'b0}};
    end
    count = count_r;
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: RV32I instruction-fetch front end.
//   clk, reset                       - clock, synchronous active-high reset
//   pc                               - next address to request
//   imem_req_valid/ready/addr        - word request port to instruction memory
//   imem_rsp_valid/data              - in-order responses, no backpressure
//   redirect_valid/pc                - restart fetch at a new PC, discarding stale work
//   id_valid/ready, id_pc, id_instr  - {pc, instr} stream to decode
// Credit: requests in flight plus buffered instructions never exceed DEPTH,
// so the response FIFO cannot overflow even though memory cannot be stalled.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [XLEN-1:0]   pc_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic [CNT_W-1:0]  outstanding_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [CNT_W:0]    credit_sum_s;
  logic              req_fire_s;
  logic              rsp_live_s;
  logic              rsp_keep_s;
  logic              id_pop_s;
  logic [XLEN-1:0]   pend_head_s;
  logic [2*XLEN-1:0] rsp_head_s;
  fetch_pkt_t        rsp_pkt_s;
  fetch_pkt_t        head_pkt_s;

  // Handshake qualification and credit check; both counts are registered, so
  // imem_req_valid has no path from id_ready or imem_rsp_valid.
  always_comb begin
    credit_sum_s   = {1'b0, outstanding_s} + {1'b0, fifo_count_s};
    imem_req_valid = !reset && !redirect_valid && (credit_sum_s < DEPTH_SUM);
    req_fire_s     = imem_req_valid && imem_req_ready;
    // A response with nothing in flight is a protocol error and is ignored entirely.
    rsp_live_s     = imem_rsp_valid && (outstanding_s != CNT_ZERO);
    rsp_keep_s     = rsp_live_s && (drop_cnt_r == CNT_ZERO) && !redirect_valid;
    id_pop_s       = id_valid && id_ready && !redirect_valid;
    rsp_pkt_s.pc    = pend_head_s;
    rsp_pkt_s.instr = imem_rsp_data;
    head_pkt_s      = rsp_head_s;
  end

  // Fetch PC and count of in-flight responses still to be discarded after a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      drop_cnt_r <= CNT_ZERO;
    end else if (redirect_valid) begin
      pc_r       <= redirect_pc;
      // A response returning this very cycle is already discarded, so exclude it.
      drop_cnt_r <= outstanding_s - (rsp_live_s ? CNT_ONE : CNT_ZERO);
    end else begin
      if (req_fire_s) begin
        pc_r <= next_pc(pc_r);
      end else begin
        pc_r <= pc_r;
      end
      if (rsp_live_s && (drop_cnt_r != CNT_ZERO)) begin
        drop_cnt_r <= drop_cnt_r - CNT_ONE;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  // Pending-PC queue: one entry per accepted request, popped by each response.
  // Its occupancy is the outstanding-request count. Not cleared on redirect,
  // since stale responses still return and must pop their own entries.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_pend_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (req_fire_s),
    .push_data (pc_r),
    .pop       (rsp_live_s),
    .head_data (pend_head_s),
    .count     (outstanding_s)
  );

  // Response FIFO feeding decode; flushed on redirect.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_rsp_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (rsp_keep_s),
    .push_data (rsp_pkt_s),
    .pop       (id_pop_s),
    .head_data (rsp_head_s),
    .count     (fifo_count_s)
  );

  // Output mapping; all values derive from registered state.
  always_comb begin
    pc            = pc_r;
    imem_req_addr = pc_r;
    id_valid      = (fifo_count_s != CNT_ZERO);
    id_pc         = head_pkt_s.pc;
    id_instr      = head_pkt_s.instr;
  end

endmodule
